// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: scoreboard of pending destination writes,
// RAW/WAW issue stall, and round-robin arbitration between ALU (A) and load (B) writebacks.
module regfile_wb_scheduler #(
    parameter int NREGISTER = 32,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rs1,
    input  logic [4:0]           issue_rs2,
    input  logic [4:0]           issue_rd,
    output logic                 issue_ready,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [4:0]           a_rd,
    input  logic [XLEN-1:0]      a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [4:0]           b_rd,
    input  logic [XLEN-1:0]      b_data,
    output logic                 rf_we,
    output logic [4:0]           rf_rd,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [NREGISTER-1:0] busy,
    output logic                 wb_err
);

    logic [NREGISTER-1:0] busy_q, busy_d;
    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 wb_err_q, wb_err_d;
    logic                 ptr_q, ptr_d;   // 0 = A has priority, 1 = B

    logic                 issue_fire;
    logic                 wb_fire;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_data;

    // busy[0] is tied low, so index 0 never stalls an issue.
    assign issue_ready = ~(busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
    assign issue_fire  = issue_valid & issue_ready;

    assign a_ready = a_valid & (~b_valid | ~ptr_q);
    assign b_ready = b_valid & (~a_valid |  ptr_q);
    assign wb_fire = a_ready | b_ready;
    assign wb_rd   = b_ready ? b_rd   : a_rd;
    assign wb_data = b_ready ? b_data : a_data;

    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (issue_fire && issue_rd != 5'd0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        rf_we_d    = wb_fire && (wb_rd != 5'd0);
        rf_rd_d    = rf_we_d ? wb_rd   : rf_rd_q;
        rf_wdata_d = rf_we_d ? wb_data : rf_wdata_q;
        // A write to a register nobody is waiting on is a protocol violation; still written.
        wb_err_d   = wb_err_q | (rf_we_d & ~busy_q[wb_rd]);
        ptr_d      = wb_fire ? a_ready : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
            wb_err_q   <= 1'b0;
            ptr_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            wb_err_q   <= wb_err_d;
            ptr_q      <= ptr_d;
        end
    end

    assign busy     = busy_q;
    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: the driver predicts every cycle's outputs from a register-level
// model and queues them; the monitor pops and compares on the falling edge.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_ready;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        wb_err;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.NREGISTER(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_ready(issue_ready),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy(busy), .wb_err(wb_err)
    );

    typedef struct packed {
        logic        ir, ar, br;
        logic [31:0] busy;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: which registers await a write, who has priority, and the
    // register-file write scheduled for the current cycle.
    bit          m_busy[32];
    bit          m_infl[32];
    bit          m_prefer_b;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    bit          m_err;
    bit          m_known = 0;

    function automatic logic [31:0] busy_word();
        logic [31:0] w = '0;
        for (int r = 0; r < 32; r++) w[r] = m_busy[r];
        return w;
    endfunction

    task automatic step(input bit r, input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit av, input logic [4:0] ard,
                        input logic [31:0] ad, input bit bv, input logic [4:0] brd,
                        input logic [31:0] bd);
        bit ir, ga, gb, g;
        logic [4:0]  grd;
        logic [31:0] gd;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        a_valid = av; a_rd = ard; a_data = ad; b_valid = bv; b_rd = brd; b_data = bd;
        ir = !(m_busy[rs1] || m_busy[rs2] || m_busy[rd]);
        ga = av && (!bv || !m_prefer_b);
        gb = bv && (!av || m_prefer_b);
        g  = ga || gb;
        grd = gb ? brd : ard;
        gd  = gb ? bd  : ad;
        if (m_known) begin
            e.ir = ir; e.ar = ga; e.br = gb; e.busy = busy_word();
            e.we = m_we; e.rd = m_rd; e.wd = m_wd; e.err = m_err;
            exp_q.push_back(e);
        end
        if (r) begin
            foreach (m_busy[i]) begin m_busy[i] = 0; m_infl[i] = 0; end
            m_prefer_b = 0; m_we = 0; m_rd = 0; m_wd = 0; m_err = 0; m_known = 1;
        end else begin
            if (g && grd != 0 && !m_busy[grd]) m_err = 1;
            if (m_we) begin m_busy[m_rd] = 0; m_infl[m_rd] = 0; end
            if (iv && ir && rd != 0) m_busy[rd] = 1;
            if (g) m_prefer_b = ga;
            if (g && grd != 0) begin
                m_we = 1; m_rd = grd; m_wd = gd; m_infl[grd] = 1;
            end else begin
                m_we = 0;
            end
        end
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rd);
        step(0, 1, rs1, 0, rd, 0, 0, 0, 0, 0, 0);
    endtask

    // Writebacks only target registers still awaiting a write and not already granted.
    task automatic rand_cycle();
        int cand[$];
        int k;
        bit av, bv;
        logic [4:0] ard, brd;
        for (int r = 1; r < 32; r++) if (m_busy[r] && !m_infl[r]) cand.push_back(r);
        av = 0; ard = 0; bv = 0; brd = 0;
        if (cand.size() > 0 && $urandom_range(1, 0) == 1) begin
            k = $urandom_range(cand.size() - 1, 0); ard = 5'(cand[k]); cand.delete(k); av = 1;
        end else if ($urandom_range(7, 0) == 0) av = 1;
        if (cand.size() > 0 && $urandom_range(1, 0) == 1) begin
            k = $urandom_range(cand.size() - 1, 0); brd = 5'(cand[k]); bv = 1;
        end else if ($urandom_range(7, 0) == 0) bv = 1;
        step(0, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
             5'($urandom_range(31, 0)), av, ard, $urandom, bv, brd, $urandom);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_ready", 32'(issue_ready), 32'(e.ir));
                chk("a_ready",     32'(a_ready),     32'(e.ar));
                chk("b_ready",     32'(b_ready),     32'(e.br));
                chk("busy",        busy,             e.busy);
                chk("rf_we",       32'(rf_we),       32'(e.we));
                chk("rf_rd",       32'(rf_rd),       32'(e.rd));
                chk("rf_wdata",    rf_wdata,         e.wd);
                chk("wb_err",      32'(wb_err),      32'(e.err));
            end
        end
    end

    initial begin : driver
        rst = 1; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
        idle(1); idle(1); idle(1);
        // Issue rd=5, then a reader of r5 stalls until the writeback lands.
        issue(0, 5);
        issue(5, 0);
        step(0, 1, 5, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        issue(5, 0);
        issue(5, 0);
        idle(0);
        // Both sources held after reset: A,B,A,B.
        idle(1);
        for (int r = 1; r <= 5; r++) issue(0, 5'(r));
        step(0, 0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22);
        step(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 2, 32'h22);
        step(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
        step(0, 0, 0, 0, 0, 1, 5, 32'h55, 1, 4, 32'h44);
        step(0, 0, 0, 0, 0, 1, 5, 32'h55, 0, 0, 0);
        idle(0); idle(0);
        // Writeback to r0 is accepted and dropped.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hCAFE);
        idle(0);
        for (int i = 0; i < 600; i++) rand_cycle();
        // Reset overrides pending state and an in-flight writeback.
        idle(1);
        for (int r = 8; r <= 11; r++) issue(0, 5'(r));
        step(1, 0, 0, 0, 0, 1, 8, 32'h88, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h1, 1, 0, 32'h2);
        step(0, 0, 0, 0, 0, 1, 0, 32'h1, 1, 0, 32'h2);
        // Unexpected writeback to r7 raises the sticky error.
        step(0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
        idle(0); idle(0); idle(0);
        idle(1); idle(0);
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
